// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache between a fetch port and a burst read master.
// Supports an uncached single-beat bypass and a flush that is safe mid-refill.
module inst_cache_dm #(
  parameter int unsigned OFFSET_WIDTH = 6,
  parameter int unsigned INDEX_WIDTH  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_ena,
  input  logic        flush,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready
);

  localparam int unsigned WordW     = OFFSET_WIDTH - 2;
  localparam int unsigned TagW      = 32 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int unsigned Sets      = 1 << INDEX_WIDTH;
  localparam int unsigned LineWords = 1 << WordW;

  typedef enum logic [2:0] {StIdle, StLookup, StMissAr, StRefill, StResp} state_e;

  state_e            state_q;
  logic [31:2]       addr_q;
  logic              cached_q;
  logic              flushed_q;
  logic [WordW-1:0]  cnt_q;
  logic [31:0]       unc_q;
  logic [31:0]       m_araddr_q;
  logic [7:0]        m_arlen_q;
  logic              m_arvalid_q;
  logic              m_rready_q;
  logic [Sets-1:0]   valid_q;

  logic [31:0]       data_q [Sets*LineWords];
  logic [TagW-1:0]   tag_q  [Sets];

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TagW-1:0]        req_tag;
  logic [WordW-1:0]       req_word;
  logic [31:0]            stored;
  logic                   hit;
  logic                   beat;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^s_araddr[1:0];

  assign req_idx  = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag  = addr_q[31 -: TagW];
  assign req_word = addr_q[2 +: WordW];
  assign stored   = data_q[{req_idx, req_word}];
  // A flush in the lookup cycle must not let a stale line answer.
  assign hit      = cached_q & valid_q[req_idx] & (tag_q[req_idx] == req_tag) & ~flush;
  assign beat     = (state_q == StRefill) & m_rvalid & m_rready_q;

  always_comb begin
    s_rvalid = ((state_q == StLookup) & hit) | ((state_q == StResp) & ~flushed_q);
    s_rdata  = '0;
    if (s_rvalid) begin
      s_rdata = ((state_q == StResp) && !cached_q) ? unc_q : stored;
    end
  end

  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign m_arvalid = m_arvalid_q;
  assign m_rready  = m_rready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cached_q    <= 1'b0;
      flushed_q   <= 1'b0;
      cnt_q       <= '0;
      unc_q       <= '0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      valid_q     <= '0;
    end else begin
      if (flush) valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (s_arvalid) begin
            addr_q    <= s_araddr[31:2];
            cached_q  <= cache_ena;
            flushed_q <= 1'b0;
            state_q   <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            state_q <= StIdle;
          end else begin
            m_arvalid_q <= 1'b1;
            m_araddr_q  <= cached_q ? {addr_q[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}}
                                    : {addr_q, 2'b00};
            m_arlen_q   <= cached_q ? 8'(LineWords - 1) : 8'd0;
            state_q     <= StMissAr;
          end
        end
        StMissAr: begin
          if (flush) flushed_q <= 1'b1;
          if (m_arready) begin
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StRefill;
          end
        end
        StRefill: begin
          if (flush) flushed_q <= 1'b1;
          if (beat) begin
            if (cached_q) cnt_q <= cnt_q + 1'b1;
            else          unc_q <= m_rdata;
            if (m_rlast) begin
              m_rready_q <= 1'b0;
              state_q    <= StResp;
              // Any flush seen during the burst leaves the line invalid.
              if (cached_q && !flush && !flushed_q) valid_q[req_idx] <= 1'b1;
            end
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat && cached_q) begin
      data_q[{req_idx, cnt_q}] <= m_rdata;
      if (m_rlast) tag_q[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_inst_cache_dm.sv
// Directed bench for inst_cache_dm with a burst RAM model returning word = byte address.
module tb_inst_cache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_ena;
  logic        flush;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;

  inst_cache_dm dut (
    .clk       (clk),
    .rst       (rst),
    .cache_ena (cache_ena),
    .flush     (flush),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_rdata   (s_rdata),
    .s_rvalid  (s_rvalid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rvalid  (m_rvalid),
    .m_rlast   (m_rlast),
    .m_rready  (m_rready)
  );

  always #5 clk = ~clk;

  // Burst RAM model, reset together with the cache.
  logic        busy;
  logic [31:0] base;
  logic [7:0]  len;
  logic [7:0]  idx;
  int          ar_cnt = 0;
  int          beat_cnt = 0;
  int          rv_cnt = 0;
  logic [31:0] last_araddr = '0;
  logic [7:0]  last_arlen = '0;

  assign m_arready = ~busy;
  assign m_rvalid  = busy;
  assign m_rdata   = base + (32'(idx) << 2);
  assign m_rlast   = busy && (idx == len);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      base <= '0;
      len  <= '0;
      idx  <= '0;
    end else if (!busy) begin
      if (m_arvalid) begin
        busy        <= 1'b1;
        base        <= m_araddr;
        len         <= m_arlen;
        idx         <= '0;
        ar_cnt      <= ar_cnt + 1;
        last_araddr <= m_araddr;
        last_arlen  <= m_arlen;
      end
    end else if (m_rready) begin
      beat_cnt <= beat_cnt + 1;
      if (idx == len) busy <= 1'b0;
      else            idx  <= idx + 8'd1;
    end
  end

  always @(posedge clk) if (s_rvalid) rv_cnt <= rv_cnt + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE and wait for its response; returns in IDLE.
  task automatic do_req(input logic [31:0] a, input logic ena, output logic got,
                        output logic [31:0] d, output int waits, output int ars);
    int ar0;
    ar0 = ar_cnt;
    got = 1'b0;
    d = '0;
    waits = 0;
    s_araddr = a;
    cache_ena = ena;
    s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (s_rvalid) begin
        got = 1'b1;
        d = s_rdata;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    ars = ar_cnt - ar0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        ena;
    logic [31:0] exp_data;
    int          exp_ars;
    logic [31:0] exp_araddr;
    logic [7:0]  exp_arlen;
    int          exp_waits;
  } vec_t;

  vec_t vecs[10];

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_rvalid"}, 32'(s_rvalid), 32'd0);
    check({tag, "_s_rdata"}, s_rdata, 32'd0);
    check({tag, "_m_arvalid"}, 32'(m_arvalid), 32'd0);
    check({tag, "_m_araddr"}, m_araddr, 32'd0);
    check({tag, "_m_arlen"}, 32'(m_arlen), 32'd0);
    check({tag, "_m_rready"}, 32'(m_rready), 32'd0);
  endtask

  logic        got;
  logic [31:0] d;
  int          waits;
  int          ars;
  int          b0;
  int          rv0;

  initial begin
    // hit: 0 waits; cached miss: AR at N+2, 16 beats, RESP at N+19 -> 18; uncached -> 3.
    vecs[0] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1, 32'h0000_0000, 8'd15, 18};
    vecs[1] = '{32'h0000_0004, 1'b1, 32'h0000_0004, 0, 32'h0,         8'd0,  0};
    vecs[2] = '{32'h0000_0008, 1'b1, 32'h0000_0008, 0, 32'h0,         8'd0,  0};
    vecs[3] = '{32'h0000_003C, 1'b1, 32'h0000_003C, 0, 32'h0,         8'd0,  0};
    vecs[4] = '{32'h0000_0044, 1'b1, 32'h0000_0044, 1, 32'h0000_0040, 8'd15, 18};
    vecs[5] = '{32'h0000_1044, 1'b1, 32'h0000_1044, 1, 32'h0000_1040, 8'd15, 18};
    vecs[6] = '{32'h0000_0044, 1'b1, 32'h0000_0044, 1, 32'h0000_0040, 8'd15, 18};
    vecs[7] = '{32'h0000_0084, 1'b0, 32'h0000_0084, 1, 32'h0000_0084, 8'd0,  3};
    vecs[8] = '{32'h0000_0084, 1'b1, 32'h0000_0084, 1, 32'h0000_0080, 8'd15, 18};
    vecs[9] = '{32'h0000_0088, 1'b1, 32'h0000_0088, 0, 32'h0,         8'd0,  0};

    rst = 1'b1;
    cache_ena = 1'b1;
    flush = 1'b0;
    s_araddr = '0;
    s_arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].addr, vecs[i].ena, got, d, waits, ars);
      check($sformatf("v%0d_rvalid", i), 32'(got), 32'd1);
      check($sformatf("v%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("v%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
      check($sformatf("v%0d_ar_count", i), 32'(ars), 32'(vecs[i].exp_ars));
      if (vecs[i].exp_ars == 1) begin
        check($sformatf("v%0d_araddr", i), last_araddr, vecs[i].exp_araddr);
        check($sformatf("v%0d_arlen", i), 32'(last_arlen), 32'(vecs[i].exp_arlen));
      end
    end

    // Idle flush invalidates everything: 0x88 now misses.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    do_req(32'h88, 1'b1, got, d, waits, ars);
    check("idle_flush_miss", 32'(ars), 32'd1);
    check("idle_flush_data", d, 32'h88);

    // Flush at beat 5 of the 0x80 refill: burst drains, no response, line stays invalid.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    b0 = beat_cnt;
    rv0 = rv_cnt;
    s_araddr = 32'h80;
    cache_ena = 1'b1;
    s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    for (int i = 0; i < 100 && !(busy && idx == 8'd5); i++) begin
      @(posedge clk); #1;
    end
    check("flush_beat5_reached", 32'(busy && idx == 8'd5), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("flush_beats_drained", 32'(beat_cnt - b0), 32'd16);
    check("flush_no_rvalid", 32'(rv_cnt - rv0), 32'd0);
    do_req(32'h80, 1'b1, got, d, waits, ars);
    check("flush_rereq_miss", 32'(ars), 32'd1);
    check("flush_rereq_data", d, 32'h80);
    check("flush_rereq_waits", 32'(waits), 32'd18);

    // Fill line 0, then reset in the middle of a later burst.
    do_req(32'h0, 1'b1, got, d, waits, ars);
    do_req(32'h0, 1'b1, got, d, waits, ars);
    check("line0_hit_before_reset", 32'(ars), 32'd0);
    s_araddr = 32'h200;
    s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    for (int i = 0; i < 100 && !(busy && idx == 8'd3); i++) begin
      @(posedge clk); #1;
    end
    check("reset_beat3_reached", 32'(busy && idx == 8'd3), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midburst_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(32'h0, 1'b1, got, d, waits, ars);
    check("post_reset_miss", 32'(ars), 32'd1);
    check("post_reset_data", d, 32'h0);
    check("post_reset_araddr", last_araddr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_cache_dm.md
# inst_cache_dm

Parametrised direct-mapped instruction cache sitting between the CPU fetch stage (`s_*` port) and the AXI-style burst read master (`m_*` port). It is the successor to `inst_cache_fifo`. Line size and set count are parameters, and the cache drives an explicit burst length. It adds two behaviours the old cache lacks: an uncached single-beat bypass mode, and a flush that is safe during an in-flight refill. Hits return in one cycle; misses refill a full line and then answer.

## Interface
- `OFFSET_WIDTH`, 6, byte-offset bits per line (line = 2^OFFSET_WIDTH bytes, LINE_WORDS = 2^(OFFSET_WIDTH-2)); legal range 3..8.
- `INDEX_WIDTH`, 6, set-index bits (SETS = 2^INDEX_WIDTH); tag = addr[31:OFFSET_WIDTH+INDEX_WIDTH].
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset (rst=1 resets immediately).
- `cache_ena`  in  1  1 = cached access, 0 = uncached bypass; sampled at request acceptance.
- `flush`  in  1  invalidate all lines; level-sensitive, acts every cycle it is 1.
- `s_araddr`  in  32  CPU fetch address, word aligned (bits[1:0] ignored).
- `s_arvalid`  in  1  CPU request; sampled only in IDLE.
- `s_rdata`  out  32  instruction word, valid when `s_rvalid`=1.
- `s_rvalid`  out  1  one-cycle response pulse.
- `m_araddr`  out  32  burst start address.
- `m_arlen`  out  8  beats-1 (LINE_WORDS-1 cached, 0 uncached).
- `m_arvalid`  out  1  read-address valid.
- `m_arready`  in  1  read-address ready.
- `m_rdata`  in  32  read beat data.
- `m_rvalid`  in  1  read beat valid.
- `m_rlast`  in  1  last beat of burst.
- `m_rready`  out  1  read-data ready.

## Operation
- Storage: per set one valid bit, one tag, LINE_WORDS data words; valid bits are flops, so flush is single-cycle.
- States: IDLE, LOOKUP, MISS_AR, REFILL, RESP.
- IDLE: `s_arvalid`=1 latches addr and `cache_ena` into req regs -> LOOKUP. The `s_arvalid`=1 cycle that IDLE exits from is the acceptance cycle. In all other states `s_arvalid` is ignored (one outstanding request; CPU re-issues if needed).
- LOOKUP, cached, hit (valid & tag match): `s_rvalid`=1, `s_rdata`=stored word -> IDLE.
- LOOKUP, cached, miss: -> MISS_AR with `m_araddr`={addr[31:OFFSET_WIDTH], 0}, `m_arlen`=LINE_WORDS-1.
- LOOKUP, uncached: -> MISS_AR with `m_araddr`={addr[31:2],2'b00}, `m_arlen`=0. Cache contents are never read or written.
- MISS_AR: `m_arvalid`=1, address/len stable until handshake (`m_arvalid`&`m_arready`) -> REFILL, beat counter = 0.
- REFILL: `m_rready`=1. Each beat with `m_rvalid`=1:
  - cached: write word[counter] of the indexed set, counter+1 (OFFSET_WIDTH-2 bits, wraps).
  - uncached: capture `m_rdata`.
  - Beat with `m_rlast`=1: cached sets valid and writes tag; -> RESP.
- RESP: `s_rvalid`=1, `s_rdata`= requested word (word[addr[OFFSET_WIDTH-1:2]] or captured uncached word) -> IDLE.
- RAM must return exactly arlen+1 beats. Extra beats before rlast wrap the counter (overwrite, no error).
- flush:
  - In any state: clears every valid bit that cycle.
  - During MISS_AR/REFILL: the burst is drained normally, but the line is not marked valid and `s_rvalid` is suppressed in RESP. The CPU re-requests after redirect.
  - During LOOKUP: forces a miss.
  - Coincident with the `m_rlast` beat: flush wins (line stays invalid).
- Reset (any time, incl. mid-burst): state IDLE, all valid=0, counter=0, all outputs 0 (`s_rdata`, `m_araddr`, `m_arlen` = 0). The external RAM must be reset with the cache.

## Timing
- Hit: acceptance cycle N, `s_rvalid` in cycle N+1.
- Cached miss: `m_arvalid` rises N+2, with AR handshake at cycle A. `m_rready`=1 from A+1. For last beat at cycle L, `s_rvalid` at L+1.
- Uncached: same path with one beat.
- Back-to-back: a new request can be accepted the cycle after `s_rvalid` (IDLE), giving one hit per 2 cycles.
- `m_arvalid` never drops before handshake; `m_rready` is 1 only in REFILL.

## Test plan
- Cold miss, default params: reset, request 0x00000000; RAM model returns word = own byte address, 16 beats. Required: `m_araddr`=0x0, `m_arlen`=15, `s_rdata`=0x00000000 one cycle after rlast.
- Hits after fill: requests 0x04, 0x08, 0x3C. Required: `s_rvalid` 1 cycle after each request, data = address, no `m_arvalid`.
- Conflict eviction: 0x44 (new line, fill), then 0x1044 (same index, tag differs). Required: refill at 0x1040; then 0x44 misses again with `m_araddr`=0x40.
- Uncached: `cache_ena`=0, request 0x84. Required: `m_araddr`=0x84, `m_arlen`=0, `s_rdata`=0x84. A following cached 0x84 still misses.
- Flush mid-refill: flush pulse at beat 5 of the 0x80 fill. Required: all 16 beats drained, no `s_rvalid`; re-request 0x80 misses.
- Reset mid-burst: rst at beat 3. Required: all outputs 0 immediately; next 0x00 request misses.
